// File: rtl/stroke_interpolator_pkg.sv
// stroke_interpolator_pkg: colour constants shared by the cursor, canvas and stroke logic
package stroke_interpolator_pkg;
    localparam int COLOR_WIDTH = 4;
    localparam logic [COLOR_WIDTH-1:0] COLOR_NONE = 4'hF;
endpackage

// File: rtl/bresenham_stepper.sv
// bresenham_stepper: incremental Bresenham walker for one line segment.
//   clk, reset      clock and synchronous active-high reset
//   load            latch x0/y0 as the current point and x1/y1 as the end point
//   step            advance the current point by one pixel
//   x0, y0, x1, y1  segment start and end
//   x, y            pixel that the next step moves to (combinational)
//   done            current point equals the end point
module bresenham_stepper #(
    parameter int XW = 10,
    parameter int YW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          step,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          done
);
    // Two guard bits keep 2*err exact for any in-range segment.
    localparam int EW = (XW > YW ? XW : YW) + 2;
    logic [XW-1:0] cx, ex, adx;
    logic [YW-1:0] cy, ey, ady;
    logic signed [EW-1:0] err, dx, dy, e2, err_nx;
    logic sx_neg, sy_neg, mx, my;
    always_comb begin
        adx    = x1 >= x0 ? x1 - x0 : x0 - x1;
        ady    = y1 >= y0 ? y1 - y0 : y0 - y1;
        e2     = err <<< 1;
        mx     = e2 >= dy;
        my     = e2 <= dx;
        err_nx = err + (mx ? dy : '0) + (my ? dx : '0);
        x      = mx ? (sx_neg ? cx - XW'(1) : cx + XW'(1)) : cx;
        y      = my ? (sy_neg ? cy - YW'(1) : cy + YW'(1)) : cy;
        done   = cx == ex && cy == ey;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cx     <= '0;
            cy     <= '0;
            ex     <= '0;
            ey     <= '0;
            dx     <= '0;
            dy     <= '0;
            err    <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
        end else if (load) begin
            cx     <= x0;
            cy     <= y0;
            ex     <= x1;
            ey     <= y1;
            dx     <= EW'(adx);
            dy     <= -EW'(ady);
            err    <= EW'(adx) - EW'(ady);
            sx_neg <= x1 < x0;
            sy_neg <= y1 < y0;
        end else if (step) begin
            cx  <= x;
            cy  <= y;
            err <= err_nx;
        end
    end
endmodule

// File: rtl/stroke_interpolator.sv
// stroke_interpolator: joins successive cursor positions of a held stroke with Bresenham lines.
//   clk, reset            clock and synchronous active-high reset
//   enable                stroke active (left button held)
//   cursor_x, cursor_y    current cursor position
//   input_color           selected colour index
//   pixel_x, pixel_y      registered pixel to write
//   pixel_color           registered colour; COLOR_NONE means no write
//   busy                  high while a segment is being emitted
module stroke_interpolator
    import stroke_interpolator_pkg::*;
#(
    parameter  int WIDTH  = 640,
    parameter  int HEIGHT = 480,
    localparam int XW     = $clog2(WIDTH),
    localparam int YW     = $clog2(HEIGHT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [XW-1:0]          cursor_x,
    input  logic [YW-1:0]          cursor_y,
    input  logic [COLOR_WIDTH-1:0] input_color,
    output logic [XW-1:0]          pixel_x,
    output logic [YW-1:0]          pixel_y,
    output logic [COLOR_WIDTH-1:0] pixel_color,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, HOLD, DRAW} state_t;
    state_t state;
    logic [XW-1:0] last_x, step_x;
    logic [YW-1:0] last_y, step_y;
    logic [COLOR_WIDTH-1:0] line_color;
    logic load, step, done;
    assign load = state == HOLD && enable && (cursor_x != last_x || cursor_y != last_y);
    assign step = state == DRAW && !done;
    bresenham_stepper #(.XW(XW), .YW(YW)) u_stepper (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .step (step),
        .x0   (last_x),
        .y0   (last_y),
        .x1   (cursor_x),
        .y1   (cursor_y),
        .x    (step_x),
        .y    (step_y),
        .done (done)
    );
    // The start pixel is emitted straight from last_* on the load edge, so the
    // stepper only supplies pixels 2..N. last_* is not read during DRAW, which
    // lets it take the segment end at load time rather than at the endpoint.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_color <= COLOR_NONE;
            busy        <= 1'b0;
            last_x      <= '0;
            last_y      <= '0;
            line_color  <= COLOR_NONE;
        end else begin
            case (state)
                IDLE: begin
                    pixel_color <= enable ? input_color : COLOR_NONE;
                    if (enable) begin
                        pixel_x <= cursor_x;
                        pixel_y <= cursor_y;
                        last_x  <= cursor_x;
                        last_y  <= cursor_y;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    pixel_color <= load ? input_color : COLOR_NONE;
                    if (!enable) begin
                        state <= IDLE;
                    end else if (load) begin
                        pixel_x    <= last_x;
                        pixel_y    <= last_y;
                        last_x     <= cursor_x;
                        last_y     <= cursor_y;
                        line_color <= input_color;
                        busy       <= 1'b1;
                        state      <= DRAW;
                    end
                end
                DRAW: begin
                    pixel_color <= done ? COLOR_NONE : line_color;
                    if (done) begin
                        busy  <= 1'b0;
                        state <= enable ? HOLD : IDLE;
                    end else begin
                        pixel_x <= step_x;
                        pixel_y <= step_y;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
